// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game round controller: FSM states,
// per-difficulty round lengths and guess range limits.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } game_state_e;

  localparam logic [6:0] TIME_D1 = 7'd30;
  localparam logic [6:0] TIME_D2 = 7'd60;
  localparam logic [6:0] TIME_D3 = 7'd90;

  localparam logic [9:0] LIMIT_D1 = 10'd9;
  localparam logic [9:0] LIMIT_D2 = 10'd99;
  localparam logic [9:0] LIMIT_D3 = 10'd999;

  function automatic logic [6:0] round_time(input logic [1:0] digits);
    case (digits)
      2'd1:    round_time = TIME_D1;
      2'd2:    round_time = TIME_D2;
      2'd3:    round_time = TIME_D3;
      default: round_time = 7'd0;
    endcase
  endfunction

  function automatic logic [9:0] guess_limit(input logic [1:0] digits);
    case (digits)
      2'd1:    guess_limit = LIMIT_D1;
      2'd2:    guess_limit = LIMIT_D2;
      2'd3:    guess_limit = LIMIT_D3;
      default: guess_limit = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/guess_round_ctrl_if.sv
// Player-facing bus of the round controller: round/guess controls in, countdown,
// display digits, status flags and FSM state (debug) out.
interface guess_round_ctrl_if;
  import game_pkg::*;

  // Handshake: start and guess_valid are single-cycle strobes with no ready;
  // the controller samples them on every rising clk edge and never stalls.
  logic        start;
  logic [1:0]  max_digit;
  logic [9:0]  target;
  logic        guess_valid;
  logic [9:0]  guess;

  logic [6:0]  time_left;
  logic [3:0]  time_tens;
  logic [3:0]  time_ones;
  logic        playing;
  logic        win;
  logic        lose;
  logic        hint_high;
  logic        hint_low;
  logic        bad_guess;
  logic [3:0]  guess_count;
  game_state_e state;

  modport master (
    output start, max_digit, target, guess_valid, guess,
    input  time_left, time_tens, time_ones, playing, win, lose,
           hint_high, hint_low, bad_guess, guess_count, state
  );

  modport slave (
    input  start, max_digit, target, guess_valid, guess,
    output time_left, time_tens, time_ones, playing, win, lose,
           hint_high, hint_low, bad_guess, guess_count, state
  );

endinterface

// File: rtl/bin2bcd7.sv
// Combinational 7-bit binary to two BCD digits for the countdown display.
module bin2bcd7 (
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  // Values up to 127 give a tens digit of at most 12, which fits in 4 bits.
  assign o_tens = 4'(i_bin / 7'd10);
  assign o_ones = 4'(i_bin % 7'd10);

endmodule

// File: rtl/guess_round_ctrl.sv
// Round controller for a number-guessing game: countdown timer with a clock-enable
// prescaler, guess evaluation with hints, and win/lose detection.
module guess_round_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               restart,
  guess_round_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  game_state_e r_state, w_state_nx;
  logic [6:0]    r_time, w_time_nx;
  logic [PW-1:0] r_presc, w_presc_nx;
  logic [9:0]    r_target, w_target_nx;
  logic [1:0]    r_digits, w_digits_nx;
  logic [3:0]    r_count, w_count_nx;
  logic          r_hint_high, w_hint_high_nx;
  logic          r_hint_low, w_hint_low_nx;
  logic          r_bad, w_bad_nx;

  logic          w_start_ok;
  logic          w_tick;
  logic          w_won;
  logic [3:0]    w_tens;
  logic [3:0]    w_ones;

  assign w_start_ok = bus.start && (bus.max_digit != 2'd0);
  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_state     <= S_IDLE;
      r_time      <= '0;
      r_presc     <= '0;
      r_target    <= '0;
      r_digits    <= '0;
      r_count     <= '0;
      r_hint_high <= 1'b0;
      r_hint_low  <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_time      <= w_time_nx;
      r_presc     <= w_presc_nx;
      r_target    <= w_target_nx;
      r_digits    <= w_digits_nx;
      r_count     <= w_count_nx;
      r_hint_high <= w_hint_high_nx;
      r_hint_low  <= w_hint_low_nx;
      r_bad       <= w_bad_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_time_nx      = r_time;
    w_presc_nx     = r_presc;
    w_target_nx    = r_target;
    w_digits_nx    = r_digits;
    w_count_nx     = r_count;
    w_hint_high_nx = r_hint_high;
    w_hint_low_nx  = r_hint_low;
    w_bad_nx       = 1'b0;
    w_won          = 1'b0;

    // A valid start wins over any guess or tick in the same cycle, in any state.
    if (w_start_ok) begin
      w_state_nx     = S_RUN;
      w_time_nx      = round_time(bus.max_digit);
      w_presc_nx     = '0;
      w_target_nx    = bus.target;
      w_digits_nx    = bus.max_digit;
      w_count_nx     = '0;
      w_hint_high_nx = 1'b0;
      w_hint_low_nx  = 1'b0;
    end else if (r_state == S_RUN) begin
      w_presc_nx = w_tick ? '0 : r_presc + PW'(1);
      if (bus.guess_valid) begin
        if (bus.guess > guess_limit(r_digits)) begin
          w_bad_nx = 1'b1;
        end else begin
          if (r_count != 4'hF) w_count_nx = r_count + 4'd1;
          if (bus.guess > r_target) begin
            w_hint_high_nx = 1'b1;
            w_hint_low_nx  = 1'b0;
          end else if (bus.guess < r_target) begin
            w_hint_high_nx = 1'b0;
            w_hint_low_nx  = 1'b1;
          end else begin
            w_hint_high_nx = 1'b0;
            w_hint_low_nx  = 1'b0;
            w_state_nx     = S_WIN;
            w_won          = 1'b1;
          end
        end
      end
      // A winning guess discards a coincident tick, so the clock stays frozen.
      if (w_tick && !w_won) begin
        if (r_time <= 7'd1) begin
          w_time_nx  = 7'd0;
          w_state_nx = S_LOSE;
        end else begin
          w_time_nx = r_time - 7'd1;
        end
      end
    end
  end

  bin2bcd7 u_bcd (
    .i_bin  (r_time),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  assign bus.time_left   = r_time;
  assign bus.time_tens   = w_tens;
  assign bus.time_ones   = w_ones;
  assign bus.playing     = (r_state == S_RUN);
  assign bus.win         = (r_state == S_WIN);
  assign bus.lose        = (r_state == S_LOSE);
  assign bus.hint_high   = r_hint_high;
  assign bus.hint_low    = r_hint_low;
  assign bus.bad_guess   = r_bad;
  assign bus.guess_count = r_count;
  assign bus.state       = r_state;

endmodule
